// File: rtl/vga_pkg.sv
// Shared VGA 640x480 @ 60 Hz timing constants and flag types.
// Sprite address generators import this package too.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    localparam int VGA_CNT_W    = 10;
    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_SYNC_DLY = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic aactive;
    } vga_flags_t;

    // Sync outputs idle high, active area idle low.
    localparam vga_flags_t VGA_FLAGS_RST = '{hs: 1'b1, vs: 1'b1, aactive: 1'b0};

    function automatic logic in_range(input logic [VGA_CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the sprite/colour path.
interface vga_timing_if;
    import vga_pkg::*;

    logic                 o_pix_stb;
    logic [VGA_CNT_W-1:0] o_xx;
    logic [VGA_CNT_W-1:0] o_yy;
    logic                 o_aactive;
    logic                 o_hs;
    logic                 o_vs;
    logic                 o_aactive_d;
    logic                 o_hs_d;
    logic                 o_vs_d;
    logic                 o_frame;
    logic                 o_animate;

    modport master (
        output o_pix_stb, o_xx, o_yy, o_aactive, o_hs, o_vs,
               o_aactive_d, o_hs_d, o_vs_d, o_frame, o_animate
    );

    modport slave (
        input  o_pix_stb, o_xx, o_yy, o_aactive, o_hs, o_vs,
               o_aactive_d, o_hs_d, o_vs_d, o_frame, o_animate
    );

endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register with a per-bit reset pattern; shifts every clock
// so the flags line up with the sprite ROM read latency.
module vga_sync_delay #(
    parameter int             DEPTH   = 2,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] dly_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dly_q <= {DEPTH{RST_VAL}};
        end else begin
            dly_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign q_o = dly_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-clock divider, x/y counters, sync/active decode
// and frame/animate pulses, plus delayed flag copies for the sprite pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int SYNC_DLY = VGA_SYNC_DLY
) (
    input  logic         i_clk,
    input  logic         i_rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [VGA_CNT_W-1:0] X_LAST   = VGA_CNT_W'(H_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] Y_LAST   = VGA_CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    logic [VGA_CNT_W-1:0] xx_q, xx_d;
    logic [VGA_CNT_W-1:0] yy_q, yy_d;
    vga_flags_t           flags_q, flags_d, flags_dly;
    logic                 stb_q;
    logic                 frame_q, frame_d;
    logic                 anim_q, anim_d;

    // Flags are decoded from the next counter values so that, once registered,
    // they describe the same pixel the counters show.
    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;
        xx_d   = (xx_q == X_LAST) ? '0 : xx_q + 1'b1;
        yy_d   = yy_q;
        if (xx_q == X_LAST) begin
            yy_d = (yy_q == Y_LAST) ? '0 : yy_q + 1'b1;
        end
        flags_d.aactive = (int'(xx_d) < H_ACTIVE) && (int'(yy_d) < V_ACTIVE);
        flags_d.hs      = !in_range(xx_d, HS_START, HS_END);
        flags_d.vs      = !in_range(yy_d, VS_START, VS_END);
        frame_d = tick && (xx_d == '0) && (yy_d == '0);
        anim_d  = tick && (int'(xx_d) == H_ACTIVE) && (int'(yy_d) == V_ACTIVE - 1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q   <= '0;
            stb_q   <= 1'b0;
            xx_q    <= X_LAST;
            yy_q    <= Y_LAST;
            flags_q <= VGA_FLAGS_RST;
            frame_q <= 1'b0;
            anim_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            stb_q   <= tick;
            frame_q <= frame_d;
            anim_q  <= anim_d;
            if (tick) begin
                xx_q    <= xx_d;
                yy_q    <= yy_d;
                flags_q <= flags_d;
            end
        end
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .W       (3),
        .RST_VAL (VGA_FLAGS_RST)
    ) u_sync_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d_i   (flags_q),
        .q_o   (flags_dly)
    );

    assign vga.o_pix_stb   = stb_q;
    assign vga.o_xx        = xx_q;
    assign vga.o_yy        = yy_q;
    assign vga.o_aactive   = flags_q.aactive;
    assign vga.o_hs        = flags_q.hs;
    assign vga.o_vs        = flags_q.vs;
    assign vga.o_aactive_d = flags_dly.aactive;
    assign vga.o_hs_d      = flags_dly.hs;
    assign vga.o_vs_d      = flags_dly.vs;
    assign vga.o_frame     = frame_q;
    assign vga.o_animate   = anim_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full horizontal timing, shortened
// vertical timing (8 lines/frame) so a whole frame fits in a short run.
module tb_vga_timing_gen;

    localparam int V_ACT  = 4;
    localparam int V_FPL  = 1;
    localparam int V_SYN  = 2;
    localparam int V_BPL  = 1;
    localparam int V_TOT  = V_ACT + V_FPL + V_SYN + V_BPL;   // 8
    localparam int FRAME_CLK = 800 * 4 * V_TOT;              // 25600

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t_frame0 = 0;

    vga_timing_if vif ();

    vga_timing_gen #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPL),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPL),
        .CLK_DIV  (4),
        .SYNC_DLY (2)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .vga   (vif)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_xx"},   vif.o_xx, 799);
        chk({tag, "_yy"},   vif.o_yy, V_TOT - 1);
        chk({tag, "_aa"},   vif.o_aactive, 0);
        chk({tag, "_hs"},   vif.o_hs, 1);
        chk({tag, "_vs"},   vif.o_vs, 1);
        chk({tag, "_stb"},  vif.o_pix_stb, 0);
        chk({tag, "_frm"},  vif.o_frame, 0);
        chk({tag, "_anim"}, vif.o_animate, 0);
        chk({tag, "_hsd"},  vif.o_hs_d, 1);
        chk({tag, "_vsd"},  vif.o_vs_d, 1);
        chk({tag, "_aad"},  vif.o_aactive_d, 0);
    endtask

    // Release reset on a falling edge; the 4th rising edge brings the first strobe.
    task automatic release_seq();
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge i_clk);
            chk("pre_stb", vif.o_pix_stb, 0);
            chk("pre_xx",  vif.o_xx, 799);
        end
        @(negedge i_clk);
        t_frame0 = cyc;
        chk("s1_stb",  vif.o_pix_stb, 1);
        chk("s1_xx",   vif.o_xx, 0);
        chk("s1_yy",   vif.o_yy, 0);
        chk("s1_aa",   vif.o_aactive, 1);
        chk("s1_frm",  vif.o_frame, 1);
        chk("s1_anim", vif.o_animate, 0);
        chk("s1_hs",   vif.o_hs, 1);
        chk("s1_vs",   vif.o_vs, 1);
        @(negedge i_clk);
        chk("s2_stb",  vif.o_pix_stb, 0);
        chk("s2_frm",  vif.o_frame, 0);
        chk("s2_xx",   vif.o_xx, 0);
    endtask

    task automatic run_line();
        int n = 0, last_stb = -1, gap_bad = 0, hs_lo = 0, hs_min = 9999, hs_max = -1;
        int aa_fall = -1, dly_bad = 0, nh = 0, prev_xx = 0;
        logic [2:0] h1 = '0, h2 = '0;
        bit done = 0;
        while (!done && n < 4000) begin
            @(negedge i_clk);
            n++;
            if (vif.o_pix_stb) begin
                if (last_stb >= 0 && n - last_stb != 4) gap_bad++;
                last_stb = n;
            end
            if (nh >= 2 && {vif.o_hs_d, vif.o_vs_d, vif.o_aactive_d} !== h2) dly_bad++;
            h2 = h1;
            h1 = {vif.o_hs, vif.o_vs, vif.o_aactive};
            nh++;
            if (vif.o_yy == 0 && !vif.o_aactive && aa_fall < 0) aa_fall = int'(vif.o_xx);
            if (!vif.o_hs) begin
                hs_lo++;
                if (int'(vif.o_xx) < hs_min) hs_min = int'(vif.o_xx);
                if (int'(vif.o_xx) > hs_max) hs_max = int'(vif.o_xx);
            end
            if (vif.o_yy == 1) begin
                done = 1;
                chk("wrap_xx",   vif.o_xx, 0);
                chk("wrap_prev", prev_xx, 799);
                chk("wrap_stb",  vif.o_pix_stb, 1);
            end
            prev_xx = int'(vif.o_xx);
        end
        chk("line_done", done, 1);
        chk("stb_gap",   gap_bad, 0);
        chk("aa_fall",   aa_fall, 640);
        chk("hs_lo_clk", hs_lo, 384);
        chk("hs_min",    hs_min, 656);
        chk("hs_max",    hs_max, 751);
        chk("dly_line",  dly_bad, 0);
    endtask

    task automatic run_frame();
        int n = 0, vs_lo = 0, vs_bad = 0, anim_n = 0;
        bit done = 0;
        while (!done && n < 30000) begin
            @(negedge i_clk);
            n++;
            if (!vif.o_vs) begin
                vs_lo++;
                if (vif.o_yy != 5 && vif.o_yy != 6) vs_bad++;
            end
            if (vif.o_animate) begin
                anim_n++;
                chk("anim_xx", vif.o_xx, 640);
                chk("anim_yy", vif.o_yy, V_ACT - 1);
            end
            if (vif.o_frame) done = 1;
        end
        chk("frame_seen", done, 1);
        chk("frame_clk",  cyc - t_frame0, FRAME_CLK);
        chk("vs_lo_clk",  vs_lo, 6400);
        chk("vs_where",   vs_bad, 0);
        chk("anim_cnt",   anim_n, 1);
    endtask

    initial begin
        int  n = 0;
        bit  found = 0;
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        check_rst("rst");
        release_seq();
        run_line();
        run_frame();

        while (!found && n < 30000) begin
            @(negedge i_clk);
            n++;
            if (vif.o_xx == 300 && vif.o_yy == 2) found = 1;
        end
        chk("find_300_2", found, 1);
        #2 i_rst = 1'b0;
        #1 check_rst("async");
        repeat (3) @(negedge i_clk);
        check_rst("hold");
        release_seq();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
